ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/alu.sv | 54 +++++
 rtl/ex_stage.sv | 89 ++++++++
 tb/tb_ex_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width default, 5-bit ALU operation codes
// and the control bundle carried through the EX/MEM register.
package cpu_pkg;
  localparam int XLEN_DEF = 32;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_JALR = 5'd10;
  localparam logic [4:0] ALU_BEQ  = 5'd11;
  localparam logic [4:0] ALU_BNE  = 5'd12;
  localparam logic [4:0] ALU_BLT  = 5'd13;
  localparam logic [4:0] ALU_BGE  = 5'd14;
  localparam logic [4:0] ALU_BLTU = 5'd15;
  localparam logic [4:0] ALU_BGEU = 5'd16;
  localparam logic [4:0] ALU_IMM  = 5'd17;

  typedef struct packed {
    logic [4:0] rd_addr;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_funct3;
  } ex_ctrl_t;
endpackage

// File: rtl/alu.sv
// Combinational ALU plus branch comparator. Branches always compare op_a
// against cmp_b (the raw rs2 value), never the muxed operand B.
module alu
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [4:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [XLEN-1:0] cmp_b,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] result,
  output logic            taken
);
  logic [4:0] shamt;
  logic       lt, ltu, beq, blt, bltu;

  always_comb begin
    shamt  = op_b[4:0];
    lt     = $signed(op_a) < $signed(op_b);
    ltu    = op_a < op_b;
    beq    = op_a == cmp_b;
    blt    = $signed(op_a) < $signed(cmp_b);
    bltu   = op_a < cmp_b;
    result = '0;
    taken  = 1'b0;
    case (alu_ctrl)
      ALU_ADD:  result = op_a + op_b;
      ALU_SUB:  result = op_a - op_b;
      ALU_SLL:  result = op_a << shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, ltu};
      ALU_XOR:  result = op_a ^ op_b;
      ALU_SRL:  result = op_a >> shamt;
      ALU_SRA:  result = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:   result = op_a | op_b;
      ALU_AND:  result = op_a & op_b;
      ALU_JALR: begin
        result = pc + XLEN'(4);
        taken  = 1'b1;
      end
      ALU_BEQ:  taken = beq;
      ALU_BNE:  taken = !beq;
      ALU_BLT:  taken = blt;
      ALU_BGE:  taken = !blt;
      ALU_BLTU: taken = bltu;
      ALU_BGEU: taken = !bltu;
      ALU_IMM:  result = imm;
      default: ;
    endcase
  end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand muxing, branch/JALR target generation and the
// EX/MEM pipeline register with a valid/ready handshake.
module ex_stage
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_ctrl,
  input  logic            alu_src,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rd_addr,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      mem_funct3,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ex_result,
  output logic [XLEN-1:0] ex_store_data,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [2:0]      ex_mem_funct3,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);
  logic [XLEN-1:0] op_b, alu_res, target, jalr_sum;
  logic            taken, capture, load;
  ex_ctrl_t        ctrl_q;

  assign op_b     = alu_src ? imm : rs2_data;
  assign jalr_sum = rs1_data + imm;
  assign target   = (alu_ctrl == ALU_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc + imm;

  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready;
  // a same-cycle flush kills the incoming entry and its redirect
  assign load     = capture && !flush;

  alu #(.XLEN(XLEN)) u_alu (
    .alu_ctrl (alu_ctrl),
    .op_a     (rs1_data),
    .op_b     (op_b),
    .cmp_b    (rs2_data),
    .pc       (pc),
    .imm      (imm),
    .result   (alu_res),
    .taken    (taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      ex_result      <= '0;
      ex_store_data  <= '0;
      ctrl_q         <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      if (flush)                       out_valid <= 1'b0;
      else if (capture)                out_valid <= 1'b1;
      else if (out_ready && out_valid) out_valid <= 1'b0;

      if (load) begin
        ex_result     <= alu_res;
        ex_store_data <= rs2_data;
        ctrl_q        <= '{rd_addr, reg_write, mem_read, mem_write, mem_funct3};
      end

      redirect_valid <= load && taken;
      if (load && taken) redirect_pc <= target;
    end
  end

  assign ex_rd_addr    = ctrl_q.rd_addr;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_funct3 = ctrl_q.mem_funct3;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the stage.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, alu_src, reg_write, mem_read, mem_write;
  logic        flush, out_valid, out_ready;
  logic [4:0]  alu_ctrl, rd_addr, ex_rd_addr;
  logic [2:0]  mem_funct3, ex_mem_funct3;
  logic [31:0] pc, rs1_data, rs2_data, imm, ex_result, ex_store_data, redirect_pc;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, redirect_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic        m_valid, m_rv, m_rw, m_mr, m_mw;
  logic [31:0] m_res, m_store, m_rpc;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .alu_src(alu_src), .pc(pc), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .imm(imm), .rd_addr(rd_addr), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_funct3(ex_mem_funct3), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // Instruction semantics straight from the operation table.
  task automatic ref_ex(input int code, input logic [31:0] pc_i, a, r2, im, input logic src,
                        output logic [31:0] res, output logic tk, output logic [31:0] tgt);
    logic [31:0] b;
    b   = src ? im : r2;
    res = 32'd0;
    tk  = 1'b0;
    tgt = pc_i + im;
    case (code)
      0:  res = a + b;
      1:  res = a - b;
      2:  res = a << (b & 32'd31);
      3:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4:  res = (a < b) ? 32'd1 : 32'd0;
      5:  res = a ^ b;
      6:  res = a >> (b & 32'd31);
      7:  res = $signed(a) >>> (b & 32'd31);
      8:  res = a | b;
      9:  res = a & b;
      10: begin res = pc_i + 32'd4; tk = 1'b1; tgt = (a + im) & 32'hFFFF_FFFE; end
      11: tk = (a == r2);
      12: tk = (a != r2);
      13: tk = ($signed(a) < $signed(r2));
      14: tk = ($signed(a) >= $signed(r2));
      15: tk = (a < r2);
      16: tk = (a >= r2);
      17: res = im;
      default: ;
    endcase
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    logic        cap, tk;
    logic [31:0] r, tg;
    cap = in_valid && (!m_valid || out_ready);
    ref_ex(int'(alu_ctrl), pc, rs1_data, rs2_data, imm, alu_src, r, tk, tg);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_rv = 0; m_rpc = 0; m_res = 0; m_store = 0;
      m_rd = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_f3 = 0;
    end else begin
      m_rv = cap && tk && !flush;
      if (m_rv) m_rpc = tg;
      if (flush) m_valid = 0;
      else if (cap) begin
        m_valid = 1; m_res = r; m_store = rs2_data; m_rd = rd_addr;
        m_rw = reg_write; m_mr = mem_read; m_mw = mem_write; m_f3 = mem_funct3;
      end else if (out_ready) m_valid = 0;
    end
    #1;
  endtask

  task automatic set_idle();
    in_valid = 0; flush = 0; alu_ctrl = 0; alu_src = 0; pc = 0; rs1_data = 0;
    rs2_data = 0; imm = 0; rd_addr = 0; reg_write = 0; mem_read = 0; mem_write = 0;
    mem_funct3 = 0;
  endtask

  task automatic drive(input logic [4:0] code, input logic src, input logic [31:0] p, a, b, im);
    in_valid = 1; alu_ctrl = code; alu_src = src; pc = p; rs1_data = a; rs2_data = b; imm = im;
    rd_addr = 5'($urandom); reg_write = 1'($urandom); mem_read = 1'($urandom);
    mem_write = 1'($urandom); mem_funct3 = 3'($urandom);
  endtask

  task automatic test_reset();
    set_idle(); out_ready = 1; rst = 1;
    tick(); tick();
    n_tests++;
    if ({out_valid, redirect_valid, ex_reg_write, ex_mem_read, ex_mem_write} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got %b required 00000",
        {out_valid, redirect_valid, ex_reg_write, ex_mem_read, ex_mem_write});
    end
    n_tests++;
    if ({ex_result, ex_store_data, redirect_pc, ex_rd_addr, ex_mem_funct3} !== '0) begin
      n_fail++; $display("FAIL reset_data got %h %h %h %h %h required 0", ex_result,
        ex_store_data, redirect_pc, ex_rd_addr, ex_mem_funct3);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_sub();
    drive(5'd1, 0, 32'h0, 32'd5, 32'd7, 32'h0); out_ready = 1;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || ex_result !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL sub got v=%b res=%h required v=1 res=fffffffe", out_valid, ex_result);
    end
    set_idle(); tick();
  endtask

  task automatic test_sra();
    drive(5'd7, 1, 32'h0, 32'h8000_0000, 32'h1234_5678, 32'h24);
    tick();
    n_tests++;
    if (ex_result !== 32'hF800_0000) begin
      n_fail++; $display("FAIL sra got %h required f8000000", ex_result);
    end
    set_idle(); tick();
  endtask

  task automatic test_branch();
    drive(5'd13, 0, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20);
    tick();
    n_tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h120 || ex_result !== 32'h0) begin
      n_fail++; $display("FAIL blt got rv=%b pc=%h res=%h required rv=1 pc=120 res=0",
        redirect_valid, redirect_pc, ex_result);
    end
    set_idle(); tick();
    n_tests++;
    if (redirect_valid !== 1'b0) begin
      n_fail++; $display("FAIL blt_pulse_end got rv=%b required 0", redirect_valid);
    end
    drive(5'd15, 0, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20);
    tick();
    n_tests++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 32'h120) begin
      n_fail++; $display("FAIL bltu got rv=%b pc=%h required rv=0 pc=120", redirect_valid, redirect_pc);
    end
    set_idle(); tick();
  endtask

  task automatic test_jalr();
    drive(5'd10, 1, 32'h40, 32'h1001, 32'h0, 32'd2);
    tick();
    n_tests++;
    if (ex_result !== 32'h44 || redirect_pc !== 32'h1002 || redirect_valid !== 1'b1) begin
      n_fail++; $display("FAIL jalr got res=%h pc=%h rv=%b required 44 1002 1",
        ex_result, redirect_pc, redirect_valid);
    end
    set_idle(); tick();
  endtask

  task automatic test_stall();
    int pulses;
    out_ready = 0;
    drive(5'd11, 0, 32'h200, 32'd3, 32'd3, 32'h8);
    tick();
    pulses = int'(redirect_valid);
    n_tests++;
    if (out_valid !== 1'b1 || redirect_pc !== 32'h208 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_capture got v=%b pc=%h rdy=%b required 1 208 0",
        out_valid, redirect_pc, in_ready);
    end
    drive(5'd0, 0, 32'h204, 32'd10, 32'd20, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += int'(redirect_valid);
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || ex_result !== 32'h0 || ex_store_data !== 32'd3) begin
        n_fail++; $display("FAIL stall_hold[%0d] got rdy=%b v=%b res=%h st=%h required 0 1 0 3",
          i, in_ready, out_valid, ex_result, ex_store_data);
      end
    end
    n_tests++;
    if (pulses !== 1) begin
      n_fail++; $display("FAIL stall_pulses got %0d required 1", pulses);
    end
    out_ready = 1;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || ex_result !== 32'd30 || ex_store_data !== 32'd20) begin
      n_fail++; $display("FAIL stall_release got v=%b res=%h st=%h required 1 1e 14",
        out_valid, ex_result, ex_store_data);
    end
    set_idle(); tick();
  endtask

  task automatic test_flush();
    drive(5'd10, 0, 32'h80, 32'h3000, 32'h0, 32'h10);
    flush = 1;
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || redirect_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush got v=%b rv=%b required 0 0", out_valid, redirect_valid);
    end
    set_idle(); tick();
  endtask

  task automatic test_rst_stall();
    out_ready = 0;
    drive(5'd0, 0, 32'h10, 32'd1, 32'd2, 32'h0);
    reg_write = 1; rd_addr = 5'd5; mem_funct3 = 3'd2;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || ex_result !== 32'd3 || ex_rd_addr !== 5'd5) begin
      n_fail++; $display("FAIL rst_stall_load got v=%b res=%h rd=%0d required 1 3 5",
        out_valid, ex_result, ex_rd_addr);
    end
    rst = 1;
    tick();
    n_tests++;
    if ({out_valid, redirect_valid, ex_reg_write, ex_mem_read, ex_mem_write} !== 5'b0 ||
        {ex_result, ex_store_data, redirect_pc, ex_rd_addr, ex_mem_funct3} !== '0) begin
      n_fail++; $display("FAIL rst_stall_clear got v=%b res=%h st=%h rpc=%h rd=%0d f3=%0d required all 0",
        out_valid, ex_result, ex_store_data, redirect_pc, ex_rd_addr, ex_mem_funct3);
    end
    rst = 0; set_idle();
    tick();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_release got rdy=%b v=%b required 1 0", in_ready, out_valid);
    end
    out_ready = 1;
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(2) == 0) ? 32'($urandom_range(7)) : $urandom;
      b = ($urandom_range(3) == 0) ? a : (($urandom_range(2) == 0) ? 32'($urandom_range(7)) : $urandom);
      drive(5'($urandom), 1'($urandom), $urandom, a, b, $urandom);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(9) == 0);
      rst       = ($urandom_range(99) == 0);
      tick();
      n_tests++;
      if (out_valid !== m_valid || in_ready !== (!m_valid || out_ready) ||
          redirect_valid !== m_rv || redirect_pc !== m_rpc) begin
        n_fail++; $display("FAIL rand_ctl[%0d] got v=%b rdy=%b rv=%b rpc=%h required v=%b rv=%b rpc=%h",
          i, out_valid, in_ready, redirect_valid, redirect_pc, m_valid, m_rv, m_rpc);
      end
      if (m_valid) begin
        n_tests++;
        if (ex_result !== m_res || ex_store_data !== m_store ||
            {ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_funct3} !==
            {m_rd, m_rw, m_mr, m_mw, m_f3}) begin
          n_fail++; $display("FAIL rand_data[%0d] got res=%h st=%h rd=%0d required res=%h st=%h rd=%0d",
            i, ex_result, ex_store_data, ex_rd_addr, m_res, m_store, m_rd);
        end
      end
    end
    rst = 0; set_idle(); out_ready = 1; tick();
  endtask

  initial begin
    m_valid = 0; m_rv = 0; m_rpc = 0; m_res = 0; m_store = 0;
    m_rd = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_f3 = 0;
    rst = 1; out_ready = 1; set_idle();
    #1;
    test_reset();
    test_sub();
    test_sra();
    test_branch();
    test_jalr();
    test_stall();
    test_flush();
    test_rst_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
